// File: rtl/mask_stream.sv
// Pixel stream masker: buffers 1-bit mask samples in a FIFO and applies one per
// valid pixel under a frame-latched mode (pass, black, fill, dim), one-cycle latency.
module mask_stream #(
    parameter int unsigned CW    = 8,
    parameter int unsigned XW    = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iDVI_VAL,
    input  logic [XW-1:0]             iDVI_X,
    input  logic [XW-1:0]             iDVI_Y,
    input  logic [CW-1:0]             iDVI_R,
    input  logic [CW-1:0]             iDVI_G,
    input  logic [CW-1:0]             iDVI_B,
    input  logic                      iMASK_VAL,
    input  logic                      iMASK,
    input  logic [1:0]                iMODE,
    input  logic [CW-1:0]             iFILL_R,
    input  logic [CW-1:0]             iFILL_G,
    input  logic [CW-1:0]             iFILL_B,
    input  logic [2:0]                iDIM_SH,
    input  logic                      iCLR_ERR,
    output logic [XW-1:0]             oX,
    output logic [XW-1:0]             oY,
    output logic [CW-1:0]             oR,
    output logic [CW-1:0]             oG,
    output logic [CW-1:0]             oB,
    output logic                      oVAL,
    output logic [$clog2(DEPTH):0]    oLEVEL,
    output logic                      oOVF,
    output logic                      oUNF
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BLACK = 2'd1;
    localparam logic [1:0] MODE_FILL  = 2'd2;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    logic [1:0]       mode_q;
    logic [CW-1:0]    fill_r_q, fill_g_q, fill_b_q;
    logic [2:0]       dim_sh_q;

    logic             push, pop, empty, full;
    logic             do_wr, do_rd, ovf_evt, unf_evt, mask_bit;
    logic [LW-1:0]    level_nxt;

    logic             load;
    logic [1:0]       mode_sel;
    logic [CW-1:0]    fill_r_sel, fill_g_sel, fill_b_sel;
    logic [2:0]       dim_sh_sel;
    logic [CW-1:0]    r_c, g_c, b_c;

    // Reset cycles ignore both streams.
    assign push  = iMASK_VAL & ~iRST;
    assign pop   = iDVI_VAL  & ~iRST;
    assign empty = (oLEVEL == '0);
    assign full  = (oLEVEL == LW'(DEPTH));

    // FIFO control: bypass when empty with a simultaneous push, otherwise pop/push independently.
    always_comb begin
        mask_bit  = 1'b0;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        level_nxt = oLEVEL;
        if (pop) begin
            if (empty) begin
                if (push) mask_bit = iMASK;
                else      unf_evt  = 1'b1;
            end else begin
                mask_bit = mem[rptr];
                do_rd    = 1'b1;
                if (push) do_wr     = 1'b1;
                else      level_nxt = oLEVEL - LW'(1);
            end
        end else if (push) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                do_wr     = 1'b1;
                level_nxt = oLEVEL + LW'(1);
            end
        end
    end

    // A valid (0,0) pixel loads the mode set and already uses it.
    always_comb begin
        load       = iDVI_VAL && (iDVI_X == '0) && (iDVI_Y == '0);
        mode_sel   = load ? iMODE   : mode_q;
        fill_r_sel = load ? iFILL_R : fill_r_q;
        fill_g_sel = load ? iFILL_G : fill_g_q;
        fill_b_sel = load ? iFILL_B : fill_b_q;
        dim_sh_sel = load ? iDIM_SH : dim_sh_q;
    end

    function automatic logic [CW-1:0] shade(input logic [CW-1:0] p,
                                            input logic [CW-1:0] fill,
                                            input logic [1:0]    mode,
                                            input logic          m,
                                            input logic [2:0]    sh);
        logic [CW-1:0] res;
        if (mode == MODE_PASS || m) res = p;
        else if (mode == MODE_BLACK) res = '0;
        else if (mode == MODE_FILL)  res = fill;
        else                         res = p >> sh;
        return res;
    endfunction

    always_comb begin
        r_c = shade(iDVI_R, fill_r_sel, mode_sel, mask_bit, dim_sh_sel);
        g_c = shade(iDVI_G, fill_g_sel, mode_sel, mask_bit, dim_sh_sel);
        b_c = shade(iDVI_B, fill_b_sel, mode_sel, mask_bit, dim_sh_sel);
    end

    // Mask storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge iCLK) begin
        if (do_wr) mem[wptr] <= iMASK;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wptr     <= '0;
            rptr     <= '0;
            oLEVEL   <= '0;
            oOVF     <= 1'b0;
            oUNF     <= 1'b0;
            mode_q   <= '0;
            fill_r_q <= '0;
            fill_g_q <= '0;
            fill_b_q <= '0;
            dim_sh_q <= '0;
            oVAL     <= 1'b0;
            oX       <= '0;
            oY       <= '0;
            oR       <= '0;
            oG       <= '0;
            oB       <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            oLEVEL <= level_nxt;
            // A new error in the clearing cycle wins.
            oOVF <= (oOVF & ~iCLR_ERR) | ovf_evt;
            oUNF <= (oUNF & ~iCLR_ERR) | unf_evt;
            if (load) begin
                mode_q   <= iMODE;
                fill_r_q <= iFILL_R;
                fill_g_q <= iFILL_G;
                fill_b_q <= iFILL_B;
                dim_sh_q <= iDIM_SH;
            end
            oVAL <= iDVI_VAL;
            if (iDVI_VAL) begin
                oX <= iDVI_X;
                oY <= iDVI_Y;
                oR <= r_c;
                oG <= g_c;
                oB <= b_c;
            end
        end
    end

endmodule

// File: tb/tb_mask_stream.sv
// Scoreboard bench for mask_stream: directed pixels push expected outputs,
// a negedge monitor pops and compares whenever oVAL is high.
module tb_mask_stream;

    localparam int unsigned CW    = 8;
    localparam int unsigned XW    = 10;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iDVI_VAL;
    logic [XW-1:0] iDVI_X, iDVI_Y;
    logic [CW-1:0] iDVI_R, iDVI_G, iDVI_B;
    logic          iMASK_VAL, iMASK;
    logic [1:0]    iMODE;
    logic [CW-1:0] iFILL_R, iFILL_G, iFILL_B;
    logic [2:0]    iDIM_SH;
    logic          iCLR_ERR;
    logic [XW-1:0] oX, oY;
    logic [CW-1:0] oR, oG, oB;
    logic          oVAL;
    logic [LW-1:0] oLEVEL;
    logic          oOVF, oUNF;

    int checks   = 0;
    int failures = 0;

    logic [2*XW+3*CW-1:0] exp_q[$];
    logic                 mask_model[$];

    mask_stream #(.CW(CW), .XW(XW), .DEPTH(DEPTH)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iDVI_VAL(iDVI_VAL), .iDVI_X(iDVI_X), .iDVI_Y(iDVI_Y),
        .iDVI_R(iDVI_R), .iDVI_G(iDVI_G), .iDVI_B(iDVI_B),
        .iMASK_VAL(iMASK_VAL), .iMASK(iMASK), .iMODE(iMODE),
        .iFILL_R(iFILL_R), .iFILL_G(iFILL_G), .iFILL_B(iFILL_B),
        .iDIM_SH(iDIM_SH), .iCLR_ERR(iCLR_ERR),
        .oX(oX), .oY(oY), .oR(oR), .oG(oG), .oB(oB), .oVAL(oVAL),
        .oLEVEL(oLEVEL), .oOVF(oOVF), .oUNF(oUNF)
    );

    always #5 iCLK = ~iCLK;

    // Monitor: every presented output must match the oldest expected entry.
    always @(negedge iCLK) begin
        if (oVAL === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got x=%0d y=%0d rgb=%h_%h_%h expected none", oX, oY, oR, oG, oB);
            end else begin
                logic [2*XW+3*CW-1:0] e;
                e = exp_q.pop_front();
                if ({oX, oY, oR, oG, oB} !== e) begin
                    failures++;
                    $display("FAIL out_pixel got x=%0d y=%0d rgb=%h_%h_%h expected x=%0d y=%0d rgb=%h_%h_%h",
                             oX, oY, oR, oG, oB, e[43:34], e[33:24], e[23:16], e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push_mask(input logic m);
        iMASK_VAL = 1'b1;
        iMASK     = m;
        tick();
        iMASK_VAL = 1'b0;
    endtask

    // Issue one pixel (with any push already set up by the caller) and queue its expected output.
    task automatic send_pix(input logic [XW-1:0] x, input logic [XW-1:0] y,
                            input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b,
                            input logic [CW-1:0] er, input logic [CW-1:0] eg, input logic [CW-1:0] eb);
        iDVI_VAL = 1'b1;
        iDVI_X = x; iDVI_Y = y;
        iDVI_R = r; iDVI_G = g; iDVI_B = b;
        exp_q.push_back({x, y, er, eg, eb});
        tick();
        iDVI_VAL  = 1'b0;
        iMASK_VAL = 1'b0;
        iCLR_ERR  = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        logic        m;
        iRST = 1'b1; iDVI_VAL = 1'b0; iDVI_X = '0; iDVI_Y = '0;
        iDVI_R = '0; iDVI_G = '0; iDVI_B = '0;
        iMASK_VAL = 1'b0; iMASK = 1'b0; iMODE = 2'd0;
        iFILL_R = '0; iFILL_G = '0; iFILL_B = '0; iDIM_SH = '0; iCLR_ERR = 1'b0;
        tick(); tick();
        chk("rst_val", 32'(oVAL), 0);
        chk("rst_level", 32'(oLEVEL), 0);
        chk("rst_flags", 32'({oOVF, oUNF}), 0);
        chk("rst_xr", 32'({oX, oR}), 0);
        iRST = 1'b0;

        // Black mode loaded at (0,0); masks 1 then 0.
        push_mask(1'b1);
        push_mask(1'b0);
        chk("lvl_two", 32'(oLEVEL), 2);
        iMODE = 2'd1;
        send_pix(10'd0, 10'd0, 8'h80, 8'h40, 8'h20, 8'h80, 8'h40, 8'h20);
        chk("lvl_one", 32'(oLEVEL), 1);
        iMODE = 2'd3;
        send_pix(10'd1, 10'd0, 8'h80, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00);
        chk("lvl_zero", 32'(oLEVEL), 0);

        // Fill to full, overflow, full push+pop, then drain in order.
        pat = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            m = pat[i];
            mask_model.push_back(m);
            push_mask(m);
        end
        chk("full_level", 32'(oLEVEL), 16);
        chk("full_no_ovf", 32'(oOVF), 0);
        push_mask(1'b0);
        chk("ovf_set", 32'(oOVF), 1);
        chk("ovf_level", 32'(oLEVEL), 16);
        iMASK_VAL = 1'b1; iMASK = 1'b1;
        m = mask_model.pop_front();
        mask_model.push_back(1'b1);
        send_pix(10'd100, 10'd1, 8'h5A, 8'hC3, 8'h0F, m ? 8'h5A : 8'h00, m ? 8'hC3 : 8'h00, m ? 8'h0F : 8'h00);
        chk("full_pushpop_level", 32'(oLEVEL), 16);
        for (int i = 0; i < 16; i++) begin
            m = mask_model.pop_front();
            send_pix(10'(200 + i), 10'd1, 8'h5A, 8'hC3, 8'h0F,
                     m ? 8'h5A : 8'h00, m ? 8'hC3 : 8'h00, m ? 8'h0F : 8'h00);
        end
        chk("drain_level", 32'(oLEVEL), 0);
        chk("drain_ovf_sticky", 32'(oOVF), 1);
        iCLR_ERR = 1'b1; tick(); iCLR_ERR = 1'b0;
        chk("ovf_clr", 32'(oOVF), 0);

        // Underflow; clear coinciding with a new underflow keeps the flag.
        send_pix(10'd5, 10'd5, 8'h77, 8'h66, 8'h55, 8'h00, 8'h00, 8'h00);
        chk("unf_set", 32'(oUNF), 1);
        iCLR_ERR = 1'b1;
        send_pix(10'd6, 10'd5, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
        chk("unf_clr_race", 32'(oUNF), 1);
        iCLR_ERR = 1'b1; tick(); iCLR_ERR = 1'b0;
        chk("unf_clr", 32'(oUNF), 0);

        // Empty-FIFO bypass.
        iMASK_VAL = 1'b1; iMASK = 1'b1;
        send_pix(10'd7, 10'd5, 8'h33, 8'h44, 8'h55, 8'h33, 8'h44, 8'h55);
        chk("bypass_level", 32'(oLEVEL), 0);
        chk("bypass_no_unf", 32'(oUNF), 0);

        // Dim mode, mid-frame mode change ignored, then fill at next (0,0).
        iMODE = 2'd3; iDIM_SH = 3'd2;
        iMASK_VAL = 1'b1; iMASK = 1'b0;
        send_pix(10'd0, 10'd0, 8'hFF, 8'h80, 8'h03, 8'h3F, 8'h20, 8'h00);
        iMODE = 2'd2; iFILL_R = 8'h12; iFILL_G = 8'h34; iFILL_B = 8'h56; iDIM_SH = 3'd0;
        iMASK_VAL = 1'b1; iMASK = 1'b0;
        send_pix(10'd1, 10'd0, 8'h40, 8'hFF, 8'h08, 8'h10, 8'h3F, 8'h02);
        iMASK_VAL = 1'b1; iMASK = 1'b0;
        send_pix(10'd0, 10'd0, 8'h40, 8'hFF, 8'h08, 8'h12, 8'h34, 8'h56);
        tick();
        chk("idle_val", 32'(oVAL), 0);
        chk("idle_hold", 32'({oX, oR, oG, oB}), 32'({10'd0, 8'h12, 8'h34, 8'h56}));

        // Pass mode still pops the FIFO.
        iMODE = 2'd0;
        push_mask(1'b0);
        chk("pass_lvl_before", 32'(oLEVEL), 1);
        send_pix(10'd0, 10'd0, 8'h9A, 8'hBC, 8'hDE, 8'h9A, 8'hBC, 8'hDE);
        chk("pass_lvl_after", 32'(oLEVEL), 0);
        chk("pass_no_unf", 32'(oUNF), 0);

        // Level 5 with overflow, then reset mid-stream.
        for (int i = 0; i < 17; i++) push_mask(1'b1);
        for (int i = 1; i <= 11; i++)
            send_pix(10'(i), 10'd2, 8'(i), 8'hA0, 8'h0B, 8'(i), 8'hA0, 8'h0B);
        chk("pre_rst_level", 32'(oLEVEL), 5);
        chk("pre_rst_ovf", 32'(oOVF), 1);
        iRST = 1'b1; iDVI_VAL = 1'b1; iDVI_X = 10'd9; iDVI_R = 8'hEE;
        iMASK_VAL = 1'b1; iMASK = 1'b1;
        tick();
        iRST = 1'b0; iDVI_VAL = 1'b0; iMASK_VAL = 1'b0;
        chk("rst2_val", 32'(oVAL), 0);
        chk("rst2_xy", 32'({oX, oY}), 0);
        chk("rst2_rgb", 32'({oR, oG, oB}), 0);
        chk("rst2_level", 32'(oLEVEL), 0);
        chk("rst2_flags", 32'({oOVF, oUNF}), 0);
        send_pix(10'd3, 10'd3, 8'h21, 8'h43, 8'h65, 8'h21, 8'h43, 8'h65);
        chk("rst2_discarded", 32'(oUNF), 1);

        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mask_stream.md
MASK_STREAM -- requirements
Module: mask_stream

Interface
REQ-001 SHALL have parameter CW, default 8: colour channel width in bits.
REQ-002 SHALL have parameter XW, default 10: X/Y coordinate width in bits.
REQ-003 SHALL have parameter DEPTH, default 16 (power of two, >=2): mask FIFO entries.
REQ-004 SHALL have ports:
 iCLK  in  1  sole clock, all state on rising edge
 iRST  in  1  reset, synchronous, active-high
 iDVI_VAL  in  1  pixel valid
 iDVI_X, iDVI_Y  in  XW each  pixel coordinates
 iDVI_R, iDVI_G, iDVI_B  in  CW each  pixel colour
 iMASK_VAL  in  1  mask sample valid
 iMASK  in  1  mask sample, 1 = keep pixel
 iMODE  in  2  requested mode: 0 pass, 1 black, 2 fill, 3 dim
 iFILL_R, iFILL_G, iFILL_B  in  CW each  fill colour for mode 2
 iDIM_SH  in  3  right-shift for mode 3
 iCLR_ERR  in  1  clears sticky error flags
 oX, oY  out  XW each  output coordinates
 oR, oG, oB  out  CW each  output colour
 oVAL  out  1  output valid
 oLEVEL  out  $clog2(DEPTH)+1  mask FIFO occupancy
 oOVF  out  1  sticky mask overflow
 oUNF  out  1  sticky mask underflow

Function
REQ-005 SHALL buffer mask samples in a DEPTH-entry FIFO: push on iMASK_VAL, pop on iDVI_VAL.
REQ-006 SHALL pop exactly one mask sample per valid pixel, in arrival order.
REQ-007 SHALL, on push and pop in the same cycle with FIFO empty, bypass: the incoming iMASK applies to that pixel and the level stays 0.
REQ-008 SHALL, on push and pop in the same cycle with FIFO non-empty, including full, perform both and leave the level unchanged.
REQ-009 SHALL, on push without pop while full, discard the new sample, leave the FIFO unchanged and set oOVF.
REQ-010 SHALL, on a pixel arriving with the FIFO empty and no simultaneous push, use mask = 0 and set oUNF.
REQ-011 SHALL hold oOVF and oUNF set until iCLR_ERR or iRST.
REQ-012 SHALL, if iCLR_ERR and a new error occur in the same cycle, leave the flag set.
REQ-013 SHALL keep an active mode register, reset value 0.
REQ-014 SHALL load iMODE, iFILL_*, iDIM_SH into the active set only on a valid pixel with iDVI_X == 0 and iDVI_Y == 0; that pixel already uses the new values.
REQ-015 SHALL compute each output channel from pixel p and mask m under the active mode:
 mode 0: p, mask ignored
 m = 1, modes 1-3: p
 m = 0, mode 1: 0
 m = 0, mode 2: fill colour
 m = 0, mode 3: p >> DIM_SH, logical shift, CW bits
REQ-016 SHALL pop the FIFO in mode 0 exactly as in the other modes.
REQ-017 SHALL register outputs with latency 1: a valid pixel at cycle n gives oVAL = 1 with its oX/oY/colour at cycle n+1.
REQ-018 SHALL drive oVAL = 0 in any cycle after iDVI_VAL = 0, holding oX, oY, oR, oG, oB at their previous values.
REQ-019 SHALL drive oLEVEL as the registered occupancy, 0..DEPTH, updated the cycle after each push or pop.
REQ-020 SHALL let FIFO read and write pointers wrap modulo DEPTH with no loss of order.

Reset
REQ-021 SHALL, while iRST = 1 at a clock edge, clear: all outputs to 0, FIFO empty (oLEVEL = 0), pointers 0, active mode 0, fill 0, DIM_SH 0, oOVF = oUNF = 0.
REQ-022 SHALL ignore iMASK_VAL and iDVI_VAL in reset cycles; reset mid-stream discards buffered samples and any in-flight output.

Verification
REQ-023 SHALL pass: reset, then mode 1 loaded at (0,0); push mask 1,0; pixels R = 0x80, 0x80 -> outputs 0x80 then 0x00, each one cycle after input, oLEVEL 2 -> 1 -> 0.
REQ-024 SHALL pass: DEPTH = 16; push 17 samples without pixels -> oLEVEL = 16, oOVF = 1 from cycle after 17th push; 16 pops return the first 16 samples in order.
REQ-025 SHALL pass: empty FIFO; pixel without mask -> oUNF = 1, output per mask 0; iCLR_ERR pulse -> oUNF = 0 next cycle.
REQ-026 SHALL pass: empty FIFO; simultaneous iMASK_VAL (iMASK = 1) and iDVI_VAL in mode 1 -> pixel passes unchanged, oLEVEL stays 0, no oUNF.
REQ-027 SHALL pass: mode 3, DIM_SH = 2, mask 0, pixel 0xFF -> 0x3F; iMODE changed mid-frame has no effect until the next (0,0) pixel.
REQ-028 SHALL pass: iRST asserted with oLEVEL = 5 and oOVF = 1 -> next cycle all outputs 0, oLEVEL 0, flags 0.
